// File: rtl/comparator_eq.sv
// Zero detect on the ALU difference (A - B) for branch equality.
// Combinational eq/ne/group_zero plus a registered, valid-qualified copy.
module comparator_eq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned GROUP = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         s,
  input  logic                     in_valid,
  output logic                     eq,
  output logic                     ne,
  output logic [WIDTH/GROUP-1:0]   group_zero,
  output logic                     eq_r,
  output logic                     ne_r,
  output logic                     out_valid
);

  localparam int unsigned NGROUPS = WIDTH / GROUP;
  localparam int unsigned LEVELS  = (NGROUPS > 1) ? $clog2(NGROUPS) : 0;
  localparam int unsigned NPAD    = 1 << LEVELS;

  // Heap-ordered AND tree: node[1] is the root, leaves start at node[NPAD].
  logic [2*NPAD-1:1] node;

  logic eq_q, eq_d;
  logic ne_q, ne_d;
  logic valid_q, valid_d;

  for (genvar g = 0; g < NGROUPS; g++) begin : g_group
    assign group_zero[g] = ~|s[g*GROUP +: GROUP];
  end

  // Unused leaves are tied high so they never mask a nonzero group.
  for (genvar l = 0; l < NPAD; l++) begin : g_leaf
    if (l < NGROUPS) begin : g_real
      assign node[NPAD+l] = group_zero[l];
    end else begin : g_pad
      assign node[NPAD+l] = 1'b1;
    end
  end

  for (genvar i = 1; i < NPAD; i++) begin : g_node
    assign node[i] = node[2*i] & node[2*i+1];
  end

  assign eq = node[1];
  assign ne = ~node[1];

  // Capture on valid; hold the last result otherwise.
  always_comb begin
    eq_d    = eq_q;
    ne_d    = ne_q;
    valid_d = 1'b0;
    if (in_valid) begin
      eq_d    = eq;
      ne_d    = ne;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      eq_q    <= 1'b0;
      ne_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      eq_q    <= eq_d;
      ne_q    <= ne_d;
      valid_q <= valid_d;
    end
  end

  assign eq_r      = eq_q;
  assign ne_r      = ne_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_comparator_eq.sv
// Self-checking bench for comparator_eq: combinational sweeps plus a
// scoreboard for the registered path.
module tb_comparator_eq;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned GROUP = 4;
  localparam int unsigned NG    = WIDTH / GROUP;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] s;
  logic             in_valid;
  logic             eq, ne, eq_r, ne_r, out_valid;
  logic [NG-1:0]    group_zero;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic eq;
    logic ne;
  } exp_t;

  exp_t sb_q[$];
  logic m_eq  = 1'b0;
  logic m_ne  = 1'b0;
  logic exp_v = 1'b0;

  comparator_eq #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (s),
    .in_valid   (in_valid),
    .eq         (eq),
    .ne         (ne),
    .group_zero (group_zero),
    .eq_r       (eq_r),
    .ne_r       (ne_r),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [NG-1:0] model_gz(input logic [WIDTH-1:0] v);
    logic [NG-1:0] r;
    for (int k = 0; k < NG; k++) r[k] = (v[k*GROUP +: GROUP] == 4'h0);
    return r;
  endfunction

  // Apply one cycle of stimulus; push expected result, pop it when it appears.
  task automatic drive_reg(input logic r, input logic v, input logic [WIDTH-1:0] val);
    exp_t e;
    reset    = r;
    in_valid = v;
    s        = val;
    if (!r && v) begin
      e.eq = (val == '0);
      e.ne = (val != '0);
      sb_q.push_back(e);
    end
    exp_v = !r && v;
    @(posedge clk);
    #1;
    if (r) begin
      m_eq = 1'b0;
      m_ne = 1'b0;
    end else if (v) begin
      e    = sb_q.pop_front();
      m_eq = e.eq;
      m_ne = e.ne;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive_reg(1'b1, 1'b0, '0);
      checks++;
      if ({eq_r, ne_r, out_valid} !== 3'b000) begin
        errors++;
        $display("FAIL reset cyc=%0d eq_r/ne_r/out_valid=%b%b%b required 000", c, eq_r, ne_r, out_valid);
      end
    end
  endtask

  task automatic test_sweep();
    reset = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      s = WIDTH'(i);
      #1;
      checks++;
      if (eq !== (i == 0) || ne !== (i != 0)) begin
        errors++;
        $display("FAIL sweep s=%h eq=%b ne=%b required eq=%b", s, eq, ne, (i == 0));
      end
    end
  endtask

  task automatic test_walking_one();
    logic [NG-1:0] gz_exp;
    for (int k = 0; k < WIDTH; k++) begin
      s = WIDTH'(1) << k;
      gz_exp = ~(NG'(1) << (k / GROUP));
      #1;
      checks++;
      if (eq !== 1'b0 || ne !== 1'b1 || group_zero !== gz_exp) begin
        errors++;
        $display("FAIL walk k=%0d eq=%b ne=%b gz=%h required eq=0 ne=1 gz=%h", k, eq, ne, group_zero, gz_exp);
      end
    end
  endtask

  task automatic test_edges();
    logic [WIDTH-1:0] pats [4];
    logic [NG-1:0]    gz_exp;
    pats[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    pats[1] = 64'h8000_0000_0000_0000;
    pats[2] = 64'h0;
    pats[3] = 64'h0000_0100_0000_0001;
    for (int i = 0; i < 4; i++) begin
      s = pats[i];
      gz_exp = model_gz(pats[i]);
      #1;
      checks++;
      if (eq !== (pats[i] == '0) || ne !== (pats[i] != '0) || group_zero !== gz_exp) begin
        errors++;
        $display("FAIL edge s=%h eq=%b ne=%b gz=%h required eq=%b gz=%h",
                 s, eq, ne, group_zero, (pats[i] == '0), gz_exp);
      end
    end
  endtask

  task automatic test_registered();
    logic [WIDTH-1:0] vals [2];
    vals[0] = '0;
    vals[1] = 64'd5;
    for (int i = 0; i < 2; i++) begin
      drive_reg(1'b0, 1'b1, vals[i]);
      checks++;
      if (eq_r !== m_eq || ne_r !== m_ne || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL registered s=%h eq_r=%b ne_r=%b out_valid=%b required %b %b 1",
                 vals[i], eq_r, ne_r, out_valid, m_eq, m_ne);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive_reg(1'b0, 1'b0, (i % 2 == 0) ? WIDTH'(0) : WIDTH'(7));
      checks++;
      if (eq_r !== m_eq || ne_r !== m_ne || out_valid !== 1'b0 || eq !== (s == '0)) begin
        errors++;
        $display("FAIL hold cyc=%0d eq_r=%b ne_r=%b out_valid=%b eq=%b required %b %b 0 %b",
                 i, eq_r, ne_r, out_valid, eq, m_eq, m_ne, (s == '0));
      end
    end
  endtask

  task automatic test_reset_priority();
    drive_reg(1'b0, 1'b1, '0);
    checks++;
    if ({eq_r, ne_r, out_valid} !== 3'b101) begin
      errors++;
      $display("FAIL prio_setup eq_r/ne_r/out_valid=%b%b%b required 101", eq_r, ne_r, out_valid);
    end
    drive_reg(1'b1, 1'b1, '0);
    checks++;
    if ({eq_r, ne_r, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL prio eq_r/ne_r/out_valid=%b%b%b required 000", eq_r, ne_r, out_valid);
    end
    drive_reg(1'b0, 1'b0, '0);
    checks++;
    if ({eq_r, ne_r, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL prio_hold eq_r/ne_r/out_valid=%b%b%b required 000", eq_r, ne_r, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < 24; i++) begin
      v = (i % 3 == 0) ? WIDTH'(0) : {32'($urandom), 32'($urandom)};
      if (i % 5 == 1) v = WIDTH'(1) << $urandom_range(63, 0);
      drive_reg(1'b0, 1'b1, v);
      checks++;
      if (eq_r !== m_eq || ne_r !== m_ne || out_valid !== exp_v || eq !== (v == '0)) begin
        errors++;
        $display("FAIL b2b i=%0d s=%h eq_r=%b ne_r=%b out_valid=%b eq=%b required %b %b %b %b",
                 i, v, eq_r, ne_r, out_valid, eq, m_eq, m_ne, exp_v, (v == '0));
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left entries=%0d required 0", sb_q.size());
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    s        = '0;
    test_reset();
    test_sweep();
    test_walking_one();
    test_edges();
    test_registered();
    test_hold();
    test_reset_priority();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator_eq.md
Name: comparator_eq

Overview:
Equality detector for the RV64 integer/branch datapath. It takes the 64-bit difference s = A - B produced by the ALU subtractor and flags equality when s is all zeros. The combinational flag eq feeds the branch-decision logic in the same cycle. A registered copy with a valid strobe feeds pipelined consumers such as the branch-resolve stage.

Parameters:
- WIDTH, 64, width of the difference input s; must be a multiple of GROUP.
- GROUP, 4, bits per first-level zero-detect group; the reduction tree is built from these groups.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- s  input  WIDTH  subtraction result A - B.
- in_valid  input  1  s carries a live compare this cycle.
- eq  output  1  combinational; 1 iff s == 0.
- ne  output  1  combinational; always the inverse of eq.
- group_zero  output  WIDTH/GROUP  combinational; bit k = 1 iff s[GROUP*k+GROUP-1 : GROUP*k] == 0.
- eq_r  output  1  registered eq.
- ne_r  output  1  registered ne.
- out_valid  output  1  registered in_valid; qualifies eq_r and ne_r.

Behaviour:
- Combinational path:
  - eq = NOR of all WIDTH bits of s, implemented as a balanced tree: per-group NOR (group_zero), then an AND-reduction of group_zero.
  - No clock or reset dependency. Zero latency. Settles within the same cycle.
  - Only the exact all-zero pattern gives eq=1. Any single set bit, including bit 0 and bit WIDTH-1, gives eq=0.
  - s is treated as an unsigned bit pattern; sign is irrelevant.
  - ne = ~eq at all times.
  - When s is fully known, eq, ne and group_zero must be known, with no X/Z.
- Registered path (rising edge of clk):
  - reset=1: eq_r=0, ne_r=0, out_valid=0. Reset has priority over in_valid.
  - reset=0, in_valid=1: eq_r <= eq, ne_r <= ne, out_valid <= 1.
  - reset=0, in_valid=0: eq_r and ne_r hold their previous values; out_valid <= 0.
  - Latency from in_valid to out_valid is 1 cycle.
  - Back-to-back valid inputs are accepted every cycle. There is no backpressure.
- Reset mid-operation: a valid input present in the reset cycle is dropped. out_valid is 0 on the following cycle.
- Reset values hold until the first valid input after reset deasserts.
- After reset, eq_r=0 and ne_r=0 simultaneously. This is the only legal state in which eq_r == ne_r.

Test Plan:
- Sweep s = 0..65535 with upper 48 bits zero, checking after settle: eq=1 only at s=0; eq=0 and ne=1 for all other 65535 values; zero error count required.
- Walking one across all 64 bits (s = 1<<k, k = 0..63): eq=0 every time. group_zero has exactly bit k/4 cleared.
- Edge patterns: s=64'hFFFF_FFFF_FFFF_FFFF gives eq=0 and group_zero=0. s=64'h8000_0000_0000_0000 gives eq=0 and group_zero=16'h7FFF. s=0 gives eq=1 and group_zero=16'hFFFF.
- Registered path, reset held for 2 cycles: eq_r=0, ne_r=0, out_valid=0. Then in_valid=1 with s=0 gives eq_r=1, ne_r=0, out_valid=1 one cycle later. Next, in_valid=1 with s=5 gives eq_r=0, ne_r=1.
- Hold: in_valid=0 while s toggles between 0 and 7 for 3 cycles. eq_r and ne_r stay unchanged; out_valid=0.
- Reset priority: reset=1 together with in_valid=1 and s=0. The next cycle shows eq_r=0, ne_r=0, out_valid=0.
